// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths and the fetch-queue entry layout used by the instruction fetch unit.
package inst_fetch_unit_pkg;

    localparam int kInstW    = 9;
    localparam int kAddrW    = 8;
    localparam int kIfqDepth = 4;

    typedef struct packed {
        logic [kInstW-1:0] inst;
        logic [kAddrW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous FIFO of fetched {instruction, PC} entries with a single-cycle clear.
module ifq_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter  int DEPTH = kIfqDepth,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop_en;
    logic          push_en;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_en  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue is still safe.
    assign push_en = push && (!full || pop_en);
    assign count   = count_reg;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !reset && !clear) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: issues ROM reads for PC addresses, buffers returned words and hands them to the decoder.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = kIfqDepth,
    parameter int IW    = kInstW,
    parameter int AW    = kAddrW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_in,
    input  logic          pc_valid,
    output logic          pc_ready,
    input  logic          flush,
    output logic [AW-1:0] imem_addr,
    output logic          imem_rd_en,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] inst_out,
    output logic [AW-1:0] inst_pc,
    output logic          inst_valid,
    input  logic          inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          inflight_reg;
    logic [AW-1:0] pc_reg;
    logic [CW:0]   occupancy;
    logic          issue;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    fetch_entry_t  push_data;
    fetch_entry_t  head;

    // Buffered plus in-flight words: a slot is reserved at issue time so returns never drop.
    assign occupancy  = (CW+1)'(count) + (CW+1)'(inflight_reg);
    assign issue      = pc_valid && !flush && !reset && !full
                        && (occupancy < (CW+1)'(DEPTH));
    assign pc_ready   = issue;
    assign imem_rd_en = issue;
    assign imem_addr  = reset ? '0 : pc_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_reg <= 1'b0;
            pc_reg       <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                pc_reg <= pc_in;
            end
        end
    end

    assign push_data.inst = imem_rdata;
    assign push_data.pc   = pc_reg;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (inflight_reg && !flush),
        .push_data (push_data),
        .pop       (inst_ready && !flush),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign inst_valid = !empty;
    assign inst_out   = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a ROM model (ROM[a] = 9'h100 + a) and in-order pop scoreboard.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc_in;
    logic       pc_valid;
    logic       pc_ready;
    logic       flush;
    logic [7:0] imem_addr;
    logic       imem_rd_en;
    logic [8:0] imem_rdata = '0;
    logic [8:0] inst_out;
    logic [7:0] inst_pc;
    logic       inst_valid;
    logic       inst_ready;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int issues   = 0;
    logic [7:0] pc_next = '0;
    logic [7:0] exp_pc  = '0;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .flush      (flush),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready)
    );

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= 9'h100 + {1'b0, imem_addr};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive the PC, score any pop in order, advance the PC on acceptance.
    task automatic cyc();
        logic [8:0] exp_inst;
        pc_in = pc_next;
        #1;
        if (inst_valid && inst_ready && !flush && !reset) begin
            exp_inst = 9'h100 + {1'b0, exp_pc};
            check_eq("pop_pc", inst_pc, exp_pc);
            check_eq("pop_inst", inst_out, exp_inst);
            $display("pop pc=%0h inst=%0h", inst_pc, inst_out);
            exp_pc++;
            pops++;
        end
        if (pc_ready) begin
            pc_next++;
            issues++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; inst_ready = 1'b0; pc_valid = 1'b1; pc_in = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_pc_ready", pc_ready, 0);
        check_eq("rst_rd_en", imem_rd_en, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_valid", inst_valid, 0);
        check_eq("rst_inst", inst_out, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        reset = 1'b0; pc_valid = 1'b0; pc_in = '0;

        // 1: back-to-back streaming, 2-cycle latency
        pc_next = 8'h00; exp_pc = 8'h00; inst_ready = 1'b1; pops = 0;
        for (int c = 0; c < 7; c++) begin
            pc_valid = (c < 4);
            pc_in = pc_next;
            #1;
            if (c < 4) check_eq("t1_pc_ready", pc_ready, 1);
            check_eq("t1_valid", inst_valid, (c >= 2 && c < 6) ? 1 : 0);
            cyc();
        end
        check_eq("t1_pops", pops, 4);

        // 2: back-pressure fills exactly DEPTH, one pop lets one more in
        pc_next = 8'h10; exp_pc = 8'h10; inst_ready = 1'b0; pc_valid = 1'b1; pops = 0; issues = 0;
        repeat (8) cyc();
        check_eq("t2_issues", issues, 4);
        pc_in = pc_next; #1;
        check_eq("t2_blocked", pc_ready, 0);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        pc_in = pc_next; #1;
        check_eq("t2_reissue", pc_ready, 1);
        cyc();
        pc_in = pc_next; #1;
        check_eq("t2_reblock", pc_ready, 0);
        cyc();
        pc_valid = 1'b0; inst_ready = 1'b1;
        repeat (8) cyc();
        check_eq("t2_pops", pops, 5);
        check_eq("t2_issues_total", issues, 5);

        // 3: ten words through the queue with concurrent push/pop and pointer wrap
        pc_next = 8'h20; exp_pc = 8'h20; inst_ready = 1'b0; pc_valid = 1'b1; pops = 0; issues = 0;
        repeat (6) cyc();
        pc_in = pc_next; #1;
        check_eq("t3_full_block", pc_ready, 0);
        check_eq("t3_full_valid", inst_valid, 1);
        inst_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            pc_valid = (issues < 10);
            cyc();
        end
        check_eq("t3_issues", issues, 10);
        check_eq("t3_pops", pops, 10);

        // 4: flush with 3 buffered + 1 in flight, then redirect to 8'h40
        pc_next = 8'h30; exp_pc = 8'h30; inst_ready = 1'b0; pc_valid = 1'b1;
        repeat (4) cyc();
        pc_in = pc_next; #1;
        check_eq("t4_pre_valid", inst_valid, 1);
        check_eq("t4_pre_pc", inst_pc, 8'h30);
        flush = 1'b1; inst_ready = 1'b1; #1;
        check_eq("t4_flush_ready", pc_ready, 0);
        cyc();
        flush = 1'b0; pc_next = 8'h40; exp_pc = 8'h40; pops = 0;
        for (int c = 0; c < 4; c++) begin
            pc_valid = (c < 2);
            pc_in = pc_next;
            #1;
            check_eq("t4_valid", inst_valid, (c >= 2) ? 1 : 0);
            if (c == 2) check_eq("t4_first_pc", inst_pc, 8'h40);
            cyc();
        end
        pc_valid = 1'b0;
        repeat (3) cyc();
        check_eq("t4_pops", pops, 2);

        // 5: reset mid-stream (2 buffered, 1 in flight)
        pc_next = 8'h50; exp_pc = 8'h50; inst_ready = 1'b0; pc_valid = 1'b1;
        repeat (3) cyc();
        reset = 1'b1; #1;
        check_eq("t5_rst_gate", pc_ready, 0);
        cyc();
        check_eq("t5_valid", inst_valid, 0);
        check_eq("t5_inst", inst_out, 0);
        check_eq("t5_inst_pc", inst_pc, 0);
        check_eq("t5_rd_en", imem_rd_en, 0);
        check_eq("t5_addr", imem_addr, 0);
        reset = 1'b0; pc_valid = 1'b0; inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            pc_in = pc_next; #1;
            check_eq("t5_no_stale", inst_valid, 0);
            cyc();
        end

        // 6: flush+reset together, then flush alone with pc_valid high
        pc_next = 8'h60; exp_pc = 8'h60; inst_ready = 1'b0; pc_valid = 1'b1;
        repeat (3) cyc();
        reset = 1'b1; flush = 1'b1;
        cyc();
        reset = 1'b0; flush = 1'b0; pc_valid = 1'b0; inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            pc_in = pc_next; #1;
            check_eq("t6_both_valid", inst_valid, 0);
            cyc();
        end
        pc_next = 8'h70; exp_pc = 8'h70; pc_valid = 1'b1; flush = 1'b1;
        pc_in = pc_next; #1;
        check_eq("t6_flush_ready", pc_ready, 0);
        check_eq("t6_flush_rden", imem_rd_en, 0);
        cyc();
        flush = 1'b0;
        pc_in = pc_next; #1;
        check_eq("t6_resume_ready", pc_ready, 1);
        check_eq("t6_resume_addr", imem_addr, 8'h70);
        cyc();
        pc_valid = 1'b0;
        repeat (4) cyc();
        check_eq("t6_drain", exp_pc, 8'h71);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
